// File: rtl/mrd_pkg.sv
// Shared types and constants for the mixed-radix DFT stage scheduler.
// Stage radices are stored as 3-bit codes that equal the radix value.
package mrd_pkg;

  localparam int MAX_STG = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FACTOR,
    S_WAIT_LOAD,
    S_RUN,
    S_WAIT_STG,
    S_UNLOAD,
    S_WAIT_OUT
  } sched_state_t;

  // Sub-phases of the serial factoring walk inside S_FACTOR.
  typedef enum logic [1:0] {
    F_FOUR,
    F_DIV3,
    F_DIV5
  } factor_phase_t;

  typedef logic [2:0] radix_t;

  localparam radix_t RDX2 = 3'd2;
  localparam radix_t RDX3 = 3'd3;
  localparam radix_t RDX4 = 3'd4;
  localparam radix_t RDX5 = 3'd5;

endpackage

// File: rtl/mrd_const_div.sv
// Serial restoring divider by the constant 3 or 5: one quotient bit per cycle,
// MSB first. Results are valid while the one-cycle done pulse is high and stay held afterwards.
module mrd_const_div #(
  parameter int NW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          div5,
  input  logic [NW-1:0] dividend,
  output logic [NW-1:0] quot,
  output logic [2:0]    rem,
  output logic          done
);
  import mrd_pkg::*;

  localparam int CW = $clog2(NW + 1);

  logic [NW-1:0] acc;
  logic [2:0]    part;
  logic [2:0]    divisor;
  logic [CW-1:0] cnt;
  logic          running;
  logic [3:0]    trial;
  logic          fits;

  // Partial remainder never exceeds 4, so the trial value fits in 4 bits (max 9).
  always_comb begin
    trial = {part, acc[NW-1]};
    fits  = (trial >= {1'b0, divisor});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      part    <= '0;
      divisor <= RDX3;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc     <= dividend;
        part    <= '0;
        divisor <= div5 ? RDX5 : RDX3;
        cnt     <= CW'(NW);
        running <= 1'b1;
      end else if (running) begin
        acc  <= {acc[NW-2:0], fits};
        part <= fits ? 3'(trial - {1'b0, divisor}) : trial[2:0];
        cnt  <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  assign quot = acc;
  assign rem  = part;

endmodule

// File: rtl/mrd_stage_sched.sv
// Frame-level stage scheduler: factors the frame's DFT size into radix-4/2/3/5
// stages, then hands them to the core one at a time before triggering unload.
module mrd_stage_sched #(
  parameter int MAX_STG = mrd_pkg::MAX_STG,
  parameter int NW      = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sink_valid,
  input  logic          sink_sop,
  input  logic          sink_eop,
  input  logic [NW-1:0] dftpts,
  output logic          sink_ready,
  output logic          stg_start,
  output logic [2:0]    stg_idx,
  output logic [2:0]    stg_radix,
  output logic [NW-1:0] stg_np,
  output logic          stg_last,
  input  logic          stg_done,
  output logic          out_start,
  input  logic          out_done,
  output logic [NW-1:0] frame_n,
  output logic          busy,
  output logic          err
);
  import mrd_pkg::*;

  localparam int CW = $clog2(MAX_STG + 1);
  localparam int IW = $clog2(MAX_STG);

  sched_state_t  state, state_nx;
  factor_phase_t phase, phase_nx;
  radix_t        stage_list [MAX_STG];
  logic [CW-1:0] count, count_nx;
  logic [NW-1:0] residue, residue_nx;
  logic [NW-1:0] np, np_nx;
  logic [2:0]    idx, idx_nx;
  logic [NW-1:0] frame_q, frame_nx;
  logic          err_q, err_nx;
  logic          load_done, load_done_nx;
  logic          stg_start_q, out_start_q;

  logic          push, list_we;
  radix_t        push_radix;
  radix_t        cur_radix;
  logic          cur_last;
  logic          sop_acc;

  logic          div_start, div_sel5, div_done;
  logic [NW-1:0] div_in, div_quot;
  logic [2:0]    div_rem;

  mrd_const_div #(.NW(NW)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .div5     (div_sel5),
    .dividend (div_in),
    .quot     (div_quot),
    .rem      (div_rem),
    .done     (div_done)
  );

  assign cur_radix = stage_list[idx[IW-1:0]];
  assign cur_last  = (count != '0) && (CW'(idx) == count - CW'(1));
  assign sop_acc   = sink_valid && sink_sop &&
                     (state == S_IDLE || state == S_FACTOR || state == S_WAIT_LOAD);

  // Next-state logic. Each divider result cycle also launches the next trial so a
  // trial costs 13 cycles; an accepted sop overrides everything at the end.
  always_comb begin
    state_nx     = state;
    phase_nx     = phase;
    count_nx     = count;
    residue_nx   = residue;
    np_nx        = np;
    idx_nx       = idx;
    frame_nx     = frame_q;
    err_nx       = err_q;
    load_done_nx = load_done;
    push         = 1'b0;
    push_radix   = RDX2;
    list_we      = 1'b0;
    div_start    = 1'b0;
    div_sel5     = 1'b0;
    div_in       = residue;

    if ((state == S_FACTOR || state == S_WAIT_LOAD) && sink_valid && sink_eop)
      load_done_nx = 1'b1;

    case (state)
      S_FACTOR: begin
        case (phase)
          F_FOUR: begin
            if (frame_q < NW'(2)) begin
              err_nx   = 1'b1;
              state_nx = S_IDLE;
            end else if (residue[1:0] == 2'b00 && residue >= NW'(4)) begin
              push       = 1'b1;
              push_radix = RDX4;
              residue_nx = residue >> 2;
            end else begin
              if (!residue[0]) begin
                push       = 1'b1;
                push_radix = RDX2;
                residue_nx = residue >> 1;
              end
              div_start = 1'b1;
              div_in    = residue_nx;
              phase_nx  = F_DIV3;
            end
          end
          F_DIV3: begin
            if (div_done) begin
              div_start = 1'b1;
              if (div_rem == 3'd0) begin
                push       = 1'b1;
                push_radix = RDX3;
                residue_nx = div_quot;
                div_in     = div_quot;
              end else begin
                div_sel5 = 1'b1;
                div_in   = residue;
                phase_nx = F_DIV5;
              end
            end
          end
          default: begin
            if (div_done) begin
              if (div_rem == 3'd0) begin
                push       = 1'b1;
                push_radix = RDX5;
                residue_nx = div_quot;
                div_start  = 1'b1;
                div_sel5   = 1'b1;
                div_in     = div_quot;
              end else if (residue == NW'(1) && count != '0) begin
                state_nx = S_WAIT_LOAD;
              end else begin
                err_nx   = 1'b1;
                state_nx = S_IDLE;
              end
            end
          end
        endcase
      end
      S_WAIT_LOAD: begin
        if (load_done)
          state_nx = S_RUN;
      end
      S_RUN: begin
        state_nx = S_WAIT_STG;
      end
      S_WAIT_STG: begin
        if (stg_done) begin
          if (cur_last) begin
            state_nx = S_UNLOAD;
          end else begin
            idx_nx   = idx + 3'd1;
            state_nx = S_RUN;
            case (cur_radix)
              RDX4:    np_nx = np << 2;
              RDX2:    np_nx = np << 1;
              RDX3:    np_nx = np + (np << 1);
              default: np_nx = np + (np << 2);
            endcase
          end
        end
      end
      S_UNLOAD: begin
        state_nx = S_WAIT_OUT;
      end
      S_WAIT_OUT: begin
        if (out_done)
          state_nx = S_IDLE;
      end
      default: ;
    endcase

    // A push into a full stage list means the size has too many factors.
    if (push) begin
      if (count == CW'(MAX_STG)) begin
        err_nx    = 1'b1;
        state_nx  = S_IDLE;
        div_start = 1'b0;
      end else begin
        list_we  = 1'b1;
        count_nx = count + CW'(1);
      end
    end

    if (sop_acc) begin
      frame_nx     = dftpts;
      residue_nx   = dftpts;
      err_nx       = 1'b0;
      load_done_nx = sink_eop;
      count_nx     = '0;
      idx_nx       = '0;
      np_nx        = NW'(1);
      phase_nx     = F_FOUR;
      state_nx     = S_FACTOR;
      list_we      = 1'b0;
      div_start    = 1'b0;
    end
  end

  // Start pulses are registered, giving the 2-cycle stg_done-to-stg_start spacing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      phase       <= F_FOUR;
      count       <= '0;
      residue     <= '0;
      np          <= '0;
      idx         <= '0;
      frame_q     <= '0;
      err_q       <= 1'b0;
      load_done   <= 1'b0;
      stg_start_q <= 1'b0;
      out_start_q <= 1'b0;
      for (int i = 0; i < MAX_STG; i++)
        stage_list[i] <= '0;
    end else begin
      state       <= state_nx;
      phase       <= phase_nx;
      count       <= count_nx;
      residue     <= residue_nx;
      np          <= np_nx;
      idx         <= idx_nx;
      frame_q     <= frame_nx;
      err_q       <= err_nx;
      load_done   <= load_done_nx;
      stg_start_q <= (state == S_RUN);
      out_start_q <= (state == S_UNLOAD);
      if (list_we)
        stage_list[count[IW-1:0]] <= push_radix;
    end
  end

  assign sink_ready = (state == S_IDLE) || (state == S_FACTOR) || (state == S_WAIT_LOAD);
  assign busy       = (state != S_IDLE);
  assign stg_start  = stg_start_q;
  assign out_start  = out_start_q;
  assign stg_idx    = idx;
  assign stg_radix  = cur_radix;
  assign stg_np     = np;
  assign stg_last   = cur_last;
  assign frame_n    = frame_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mrd_stage_sched.sv
// Directed bench for mrd_stage_sched; the core and unload side are played by
// the bench, with expected stage lists worked out by hand per frame size.
module tb_mrd_stage_sched;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic        sink_valid = 1'b0;
  logic        sink_sop   = 1'b0;
  logic        sink_eop   = 1'b0;
  logic [11:0] dftpts     = '0;
  logic        stg_done   = 1'b0;
  logic        out_done   = 1'b0;
  logic        sink_ready, stg_start, stg_last, out_start, busy, err;
  logic [2:0]  stg_idx, stg_radix;
  logic [11:0] stg_np, frame_n;

  int   checks = 0;
  int   errors = 0;
  logic seen;
  logic seen_out;

  always #5 clk = ~clk;

  mrd_stage_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sink_valid (sink_valid),
    .sink_sop   (sink_sop),
    .sink_eop   (sink_eop),
    .dftpts     (dftpts),
    .sink_ready (sink_ready),
    .stg_start  (stg_start),
    .stg_idx    (stg_idx),
    .stg_radix  (stg_radix),
    .stg_np     (stg_np),
    .stg_last   (stg_last),
    .stg_done   (stg_done),
    .out_start  (out_start),
    .out_done   (out_done),
    .frame_n    (frame_n),
    .busy       (busy),
    .err        (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One-cycle sop (optionally also eop) carrying the frame size.
  task automatic applyStimulus(input logic [11:0] n, input logic eop);
    sink_valid = 1'b1;
    sink_sop   = 1'b1;
    sink_eop   = eop;
    dftpts     = n;
    tick();
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
    dftpts     = '0;
  endtask

  task automatic expectStage(input string tag, input int idx, input int radix,
                             input int np, input int last);
    int n = 0;
    while (stg_start !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    checkOutput({tag, "_start"}, 32'(stg_start), 1);
    checkOutput({tag, "_idx"},   32'(stg_idx),   32'(idx));
    checkOutput({tag, "_radix"}, 32'(stg_radix), 32'(radix));
    checkOutput({tag, "_np"},    32'(stg_np),    32'(np));
    checkOutput({tag, "_last"},  32'(stg_last),  32'(last));
    checkOutput({tag, "_ready"}, 32'(sink_ready), 0);
    tick();
    checkOutput({tag, "_pulse"}, 32'(stg_start), 0);
    tick();
    tick();
    checkOutput({tag, "_hold"},  32'(stg_radix), 32'(radix));
  endtask

  task automatic finishStage();
    stg_done = 1'b1;
    tick();
    stg_done = 1'b0;
  endtask

  task automatic expectUnload(input string tag);
    int n = 0;
    while (out_start !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checkOutput({tag, "_out_start"}, 32'(out_start), 1);
    tick();
    checkOutput({tag, "_out_pulse"}, 32'(out_start), 0);
    checkOutput({tag, "_busy_out"},  32'(busy), 1);
    out_done = 1'b1;
    tick();
    out_done = 1'b0;
    checkOutput({tag, "_idle"},  32'(busy), 0);
    checkOutput({tag, "_ready"}, 32'(sink_ready), 1);
  endtask

  // Bad sizes must fall back to IDLE with err set and never start a stage.
  task automatic expectError(input string tag);
    int n = 0;
    logic s = 1'b0;
    while (busy === 1'b1 && n < 400) begin
      tick();
      if (stg_start === 1'b1) s = 1'b1;
      n++;
    end
    checkOutput({tag, "_idle"},     32'(busy), 0);
    checkOutput({tag, "_err"},      32'(err), 1);
    checkOutput({tag, "_no_start"}, 32'(s), 0);
  endtask

  task automatic quiet(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (stg_start === 1'b1) seen = 1'b1;
      if (out_start === 1'b1) seen_out = 1'b1;
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"},  32'(sink_ready), 1);
    checkOutput({tag, "_busy"},   32'(busy), 0);
    checkOutput({tag, "_start"},  32'(stg_start), 0);
    checkOutput({tag, "_idx"},    32'(stg_idx), 0);
    checkOutput({tag, "_radix"},  32'(stg_radix), 0);
    checkOutput({tag, "_np"},     32'(stg_np), 0);
    checkOutput({tag, "_last"},   32'(stg_last), 0);
    checkOutput({tag, "_out"},    32'(out_start), 0);
    checkOutput({tag, "_frame"},  32'(frame_n), 0);
    checkOutput({tag, "_err"},    32'(err), 0);
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    checkResetValues("rst");
    rst_n = 1'b1;
    tick();
    checkResetValues("rst_rel");

    // 1200 = 4*4*3*5*5, eop arrives 1200 cycles after sop
    $display("[TB] frame N=1200");
    applyStimulus(12'd1200, 1'b0);
    checkOutput("t1_frame_n", 32'(frame_n), 1200);
    checkOutput("t1_busy", 32'(busy), 1);
    checkOutput("t1_ready", 32'(sink_ready), 1);
    seen = 1'b0;
    sink_valid = 1'b1;
    quiet(1199);
    checkOutput("t1_no_start_before_eop", 32'(seen), 0);
    checkOutput("t1_ready_wait_load", 32'(sink_ready), 1);
    sink_eop = 1'b1;
    tick();
    sink_valid = 1'b0;
    sink_eop   = 1'b0;
    expectStage("t1_s0", 0, 4, 1, 0);   finishStage();
    expectStage("t1_s1", 1, 4, 4, 0);   finishStage();
    expectStage("t1_s2", 2, 3, 16, 0);  finishStage();
    expectStage("t1_s3", 3, 5, 48, 0);  finishStage();
    expectStage("t1_s4", 4, 5, 240, 1); finishStage();
    expectUnload("t1");

    // Small sizes and a deep radix-3 chain
    $display("[TB] frames N=12, 6, 1296");
    applyStimulus(12'd12, 1'b1);
    expectStage("t2a_s0", 0, 4, 1, 0); finishStage();
    expectStage("t2a_s1", 1, 3, 4, 1); finishStage();
    expectUnload("t2a");
    applyStimulus(12'd6, 1'b1);
    expectStage("t2b_s0", 0, 2, 1, 0); finishStage();
    expectStage("t2b_s1", 1, 3, 2, 1); finishStage();
    expectUnload("t2b");
    applyStimulus(12'd1296, 1'b1);
    expectStage("t2c_s0", 0, 4, 1, 0);   finishStage();
    expectStage("t2c_s1", 1, 4, 4, 0);   finishStage();
    expectStage("t2c_s2", 2, 3, 16, 0);  finishStage();
    expectStage("t2c_s3", 3, 3, 48, 0);  finishStage();
    expectStage("t2c_s4", 4, 3, 144, 0); finishStage();
    expectStage("t2c_s5", 5, 3, 432, 1); finishStage();
    expectUnload("t2c");

    // Unfactorable sizes, then recovery with 60 = 4*3*5
    $display("[TB] bad sizes 7, 1, 0 then N=60");
    applyStimulus(12'd7, 1'b1);
    expectError("t3_n7");
    applyStimulus(12'd1, 1'b1);
    expectError("t3_n1");
    applyStimulus(12'd0, 1'b1);
    expectError("t3_n0");
    applyStimulus(12'd60, 1'b1);
    checkOutput("t3_err_cleared", 32'(err), 0);
    expectStage("t3_s0", 0, 4, 1, 0);  finishStage();
    expectStage("t3_s1", 1, 3, 4, 0);  finishStage();
    expectStage("t3_s2", 2, 5, 12, 1); finishStage();
    expectUnload("t3");

    // eop lands while factoring is still in progress
    $display("[TB] early eop N=1296");
    applyStimulus(12'd1296, 1'b0);
    sink_valid = 1'b1;
    tick();
    tick();
    sink_eop = 1'b1;
    tick();
    sink_valid = 1'b0;
    sink_eop   = 1'b0;
    seen = 1'b0;
    quiet(30);
    checkOutput("t4_no_early_start", 32'(seen), 0);
    checkOutput("t4_still_factoring", 32'(sink_ready), 1);
    expectStage("t4_s0", 0, 4, 1, 0);   finishStage();
    expectStage("t4_s1", 1, 4, 4, 0);   finishStage();
    expectStage("t4_s2", 2, 3, 16, 0);  finishStage();
    expectStage("t4_s3", 3, 3, 48, 0);  finishStage();
    expectStage("t4_s4", 4, 3, 144, 0); finishStage();
    expectStage("t4_s5", 5, 3, 432, 1); finishStage();
    expectUnload("t4");

    // Restart in WAIT_LOAD drops the 300-point frame
    $display("[TB] restart in WAIT_LOAD");
    applyStimulus(12'd300, 1'b0);
    sink_valid = 1'b1;
    seen = 1'b0;
    quiet(150);
    checkOutput("t5_no_start_300", 32'(seen), 0);
    checkOutput("t5_wait_load_ready", 32'(sink_ready), 1);
    checkOutput("t5_frame_300", 32'(frame_n), 300);
    sink_sop = 1'b1;
    sink_eop = 1'b1;
    dftpts   = 12'd12;
    tick();
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
    dftpts     = '0;
    checkOutput("t5_frame_12", 32'(frame_n), 12);
    expectStage("t5_s0", 0, 4, 1, 0); finishStage();
    expectStage("t5_s1", 1, 3, 4, 1); finishStage();
    expectUnload("t5");
    seen = 1'b0;
    quiet(40);
    checkOutput("t5_no_leftover", 32'(seen), 0);

    // sop during WAIT_STG is ignored
    $display("[TB] sop during WAIT_STG");
    applyStimulus(12'd6, 1'b1);
    expectStage("t5b_s0", 0, 2, 1, 0);
    applyStimulus(12'd12, 1'b1);
    checkOutput("t5b_frame_kept", 32'(frame_n), 6);
    checkOutput("t5b_idx_kept", 32'(stg_idx), 0);
    checkOutput("t5b_busy", 32'(busy), 1);
    finishStage();
    expectStage("t5b_s1", 1, 3, 2, 1); finishStage();
    expectUnload("t5b");

    // Asynchronous reset in WAIT_STG of stage 2, then a late stg_done
    $display("[TB] reset mid-frame");
    applyStimulus(12'd60, 1'b1);
    expectStage("t6_s0", 0, 4, 1, 0);  finishStage();
    expectStage("t6_s1", 1, 3, 4, 0);  finishStage();
    expectStage("t6_s2", 2, 5, 12, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("t6_rst");
    tick();
    rst_n = 1'b1;
    stg_done = 1'b1;
    tick();
    stg_done = 1'b0;
    seen     = 1'b0;
    seen_out = 1'b0;
    quiet(10);
    checkOutput("t6_late_done_no_start", 32'(seen), 0);
    checkOutput("t6_late_done_no_out", 32'(seen_out), 0);
    checkOutput("t6_idle", 32'(busy), 0);
    applyStimulus(12'd12, 1'b1);
    expectStage("t6b_s0", 0, 4, 1, 0); finishStage();
    expectStage("t6b_s1", 1, 3, 4, 1); finishStage();
    expectUnload("t6b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
